// File: rtl/pixel_dispatch_scheduler.sv
// Raster pixel scheduler: issues coordinates round-robin to NUM_ENG engines and retires
// their results in the same order through a one-stage AXI-Stream output register.
module pixel_dispatch_scheduler #(
   parameter int X_SIZE  = 640,
   parameter int Y_SIZE  = 480,
   parameter int XW      = 10,
   parameter int YW      = 9,
   parameter int NUM_ENG = 4
) (
   input  logic                  out_stream_aclk,
   input  logic                  periph_reset,
   input  logic                  start,
   input  logic                  continuous,
   output logic                  busy,
   output logic                  frame_done,
   output logic [NUM_ENG-1:0]    eng_req_valid,
   input  logic [NUM_ENG-1:0]    eng_req_ready,
   output logic [XW-1:0]         eng_x,
   output logic [YW-1:0]         eng_y,
   input  logic [NUM_ENG-1:0]    eng_rsp_valid,
   input  logic [32*NUM_ENG-1:0] eng_rsp_data,
   output logic [NUM_ENG-1:0]    eng_rsp_ready,
   output logic [31:0]           out_stream_tdata,
   output logic [3:0]            out_stream_tkeep,
   output logic                  out_stream_tvalid,
   input  logic                  out_stream_tready,
   output logic                  out_stream_tuser,
   output logic                  out_stream_tlast
);
   localparam int PW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
   localparam logic [PW-1:0] LAST_ENG = PW'(NUM_ENG - 1);
   localparam logic [XW-1:0] LAST_X   = XW'(X_SIZE - 1);
   localparam logic [YW-1:0] LAST_Y   = YW'(Y_SIZE - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;
   state_t r_state, w_state_nxt;

   logic [PW-1:0]      r_iptr, r_rptr;
   logic [XW-1:0]      r_x, r_rx;
   logic [YW-1:0]      r_y, r_ry;
   logic [NUM_ENG-1:0] r_pending;
   logic [31:0]        r_tdata;
   logic               r_tvalid, r_tuser, r_tlast, r_teof, r_frame_done;

   logic [NUM_ENG-1:0] w_ionehot, w_ronehot;
   logic               w_issue, w_retire, w_out_free, w_last_acc, w_iss_last;
   logic [31:0]        w_rsp_word;

   // One-hot pointer decodes keep indexing in range for any NUM_ENG.
   assign w_ionehot  = NUM_ENG'(1) << r_iptr;
   assign w_ronehot  = NUM_ENG'(1) << r_rptr;
   assign w_out_free = !r_tvalid || out_stream_tready;
   assign w_iss_last = (r_x == LAST_X) && (r_y == LAST_Y);
   assign w_last_acc = r_tvalid && out_stream_tready && r_teof;
   assign w_issue    = |(eng_req_valid & eng_req_ready);
   assign w_retire   = |(eng_rsp_ready & eng_rsp_valid);

   always_comb begin
      eng_req_valid = '0;
      eng_rsp_ready = '0;
      if (r_state == S_RUN && !(|(r_pending & w_ionehot)))
         eng_req_valid = w_ionehot;
      if (r_state != S_IDLE && (|(r_pending & w_ronehot)) && w_out_free)
         eng_rsp_ready = w_ronehot;
   end

   always_comb begin
      w_rsp_word = '0;
      for (int unsigned i = 0; i < NUM_ENG; i++)
         if (r_rptr == PW'(i)) w_rsp_word = eng_rsp_data[32*i +: 32];
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_nxt = S_RUN;
         S_RUN:   if (w_issue && w_iss_last) w_state_nxt = S_DRAIN;
         S_DRAIN: if (w_last_acc) w_state_nxt = continuous ? S_RUN : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge out_stream_aclk) begin
      if (periph_reset) r_state <= S_IDLE;
      else              r_state <= w_state_nxt;
   end

   always_ff @(posedge out_stream_aclk) begin
      if (periph_reset) begin
         r_iptr       <= '0;
         r_rptr       <= '0;
         r_x          <= '0;
         r_y          <= '0;
         r_rx         <= '0;
         r_ry         <= '0;
         r_pending    <= '0;
         r_tdata      <= '0;
         r_tvalid     <= 1'b0;
         r_tuser      <= 1'b0;
         r_tlast      <= 1'b0;
         r_teof       <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_last_acc;
         r_pending    <= (r_pending & ~(w_retire ? w_ronehot : '0)) | (w_issue ? w_ionehot : '0);
         if (w_issue) begin
            r_iptr <= (r_iptr == LAST_ENG) ? '0 : r_iptr + 1'b1;
            if (r_x == LAST_X) begin
               r_x <= '0;
               r_y <= (r_y == LAST_Y) ? '0 : r_y + 1'b1;
            end else begin
               r_x <= r_x + 1'b1;
            end
         end
         if (w_retire) begin
            r_rptr   <= (r_rptr == LAST_ENG) ? '0 : r_rptr + 1'b1;
            r_tdata  <= w_rsp_word;
            r_tvalid <= 1'b1;
            r_tuser  <= (r_rx == '0) && (r_ry == '0);
            r_tlast  <= (r_rx == LAST_X);
            r_teof   <= (r_rx == LAST_X) && (r_ry == LAST_Y);
            if (r_rx == LAST_X) begin
               r_rx <= '0;
               r_ry <= (r_ry == LAST_Y) ? '0 : r_ry + 1'b1;
            end else begin
               r_rx <= r_rx + 1'b1;
            end
         end else if (out_stream_tready) begin
            r_tvalid <= 1'b0;
            r_tuser  <= 1'b0;
            r_tlast  <= 1'b0;
            r_teof   <= 1'b0;
         end
      end
   end

   assign busy              = (r_state != S_IDLE);
   assign frame_done        = r_frame_done;
   assign eng_x             = r_x;
   assign eng_y             = r_y;
   assign out_stream_tdata  = r_tdata;
   assign out_stream_tkeep  = 4'hF;
   assign out_stream_tvalid = r_tvalid;
   assign out_stream_tuser  = r_tuser;
   assign out_stream_tlast  = r_tlast;
endmodule

// File: tb/tb_pixel_dispatch_scheduler.sv
// Bench for pixel_dispatch_scheduler: engine models plus a raster-order reference model,
// driven by a scenario table, and a hand sequence for the 1x1 single-engine build.
module tb_pixel_dispatch_scheduler;
   localparam int X = 4, Y = 2, N = 2, XW = 2, YW = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, start, continuous, busy, frame_done;
   logic [N-1:0] req_valid, req_ready, rsp_valid, rsp_ready;
   logic [XW-1:0] ex;
   logic [YW-1:0] ey;
   logic [32*N-1:0] rsp_data;
   logic [31:0] tdata;
   logic [3:0] tkeep;
   logic tvalid, tready, tuser, tlast;

   logic start1, busy1, fd1, rqv1, rqr1, rsv1, rsr1, ex1, ey1;
   logic [31:0] rsd1, tdata1;
   logic [3:0] tkeep1;
   logic tvalid1, tready1, tuser1, tlast1;

   pixel_dispatch_scheduler #(.X_SIZE(X), .Y_SIZE(Y), .XW(XW), .YW(YW), .NUM_ENG(N)) dut (
      .out_stream_aclk(clk), .periph_reset(rst), .start(start), .continuous(continuous),
      .busy(busy), .frame_done(frame_done), .eng_req_valid(req_valid), .eng_req_ready(req_ready),
      .eng_x(ex), .eng_y(ey), .eng_rsp_valid(rsp_valid), .eng_rsp_data(rsp_data),
      .eng_rsp_ready(rsp_ready), .out_stream_tdata(tdata), .out_stream_tkeep(tkeep),
      .out_stream_tvalid(tvalid), .out_stream_tready(tready), .out_stream_tuser(tuser),
      .out_stream_tlast(tlast));

   pixel_dispatch_scheduler #(.X_SIZE(1), .Y_SIZE(1), .XW(1), .YW(1), .NUM_ENG(1)) dut1 (
      .out_stream_aclk(clk), .periph_reset(rst), .start(start1), .continuous(1'b0),
      .busy(busy1), .frame_done(fd1), .eng_req_valid(rqv1), .eng_req_ready(rqr1),
      .eng_x(ex1), .eng_y(ey1), .eng_rsp_valid(rsv1), .eng_rsp_data(rsd1),
      .eng_rsp_ready(rsr1), .out_stream_tdata(tdata1), .out_stream_tkeep(tkeep1),
      .out_stream_tvalid(tvalid1), .out_stream_tready(tready1), .out_stream_tuser(tuser1),
      .out_stream_tlast(tlast1));

   typedef struct {
      int lat0; int lat1; bit rlat; bit rstall; int rmode;
      int nframes; bit mid_start; int rst_after; int exp_beats; int exp_fd;
   } case_t;

   int checks, failures;
   // engine models: an engine holds one pixel and answers {y,x} after its latency
   bit eng_busy[N];
   int eng_cnt[N];
   logic [31:0] eng_data[N];
   bit eng_stall[N];
   int lat0, lat1, rmode, phase;
   bit rand_lat, rand_stall;
   // raster reference model
   bit m_busy, m_tvalid, fd_exp;
   int n_iss, n_ret, m_ridx, ip, rp, beats, fds, frames;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         if (failures <= 40)
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int pick_lat(input int e);
      if (rand_lat) return int'($urandom_range(1, 6));
      return (e == 0) ? lat0 : lat1;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_tvalid = 0; fd_exp = 0;
      n_iss = 0; n_ret = 0; m_ridx = 0; ip = 0; rp = 0;
      for (int e = 0; e < N; e++) begin
         eng_busy[e] = 0; eng_cnt[e] = 0; eng_data[e] = '0; eng_stall[e] = 0;
      end
   endtask

   // One clock: drive at negedge, check at negedge+1, advance the models after the posedge.
   task automatic step();
      logic [N-1:0] er, erp, req_f, rsp_f;
      bit rst_s, start_s, cont_s, tr_s, acc_s, mb_pre;
      logic [XW-1:0] ex_s;
      logic [YW-1:0] ey_s;
      for (int e = 0; e < N; e++) begin
         req_ready[e] = !eng_busy[e] && !eng_stall[e];
         rsp_valid[e] = eng_busy[e] && (eng_cnt[e] == 0);
         rsp_data[32*e +: 32] = eng_data[e];
      end
      case (rmode)
         0:       tready = 1'b1;
         1:       tready = (phase % 4 == 0) || (phase % 4 == 3);
         default: tready = 1'($urandom_range(0, 1));
      endcase
      phase++;
      #1;
      er = '0;
      if (m_busy && n_iss < X*Y && !eng_busy[ip]) er[ip] = 1'b1;
      erp = '0;
      if (eng_busy[rp] && (!m_tvalid || tready)) erp[rp] = 1'b1;
      chk("busy", busy, m_busy);
      chk("frame_done", frame_done, fd_exp);
      chk("req_valid", req_valid, er);
      if (er != '0) begin
         chk("eng_x", ex, n_iss % X);
         chk("eng_y", ey, n_iss / X);
      end
      chk("rsp_ready", rsp_ready, erp);
      chk("tvalid", tvalid, m_tvalid);
      if (m_tvalid) begin
         chk("tdata", tdata, {16'(m_ridx / X), 16'(m_ridx % X)});
         chk("tuser", tuser, m_ridx == 0);
         chk("tlast", tlast, (m_ridx % X) == X-1);
      end
      req_f = req_valid & req_ready;
      rsp_f = rsp_valid & rsp_ready;
      rst_s = rst; start_s = start; cont_s = continuous; tr_s = tready;
      acc_s = tvalid && tready; ex_s = ex; ey_s = ey; mb_pre = m_busy;
      fds += int'(frame_done);
      @(negedge clk);
      fd_exp = 0;
      if (rst_s) begin
         model_reset();
      end else begin
         for (int e = 0; e < N; e++) if (eng_busy[e] && eng_cnt[e] > 0) eng_cnt[e]--;
         if (acc_s) begin
            beats++;
            if (m_ridx == X*Y-1) begin
               fd_exp = 1; frames++;
               if (cont_s) begin n_iss = 0; n_ret = 0; end
               else m_busy = 0;
            end
         end
         if (rsp_f != '0) begin
            for (int e = 0; e < N; e++) if (rsp_f[e]) eng_busy[e] = 0;
            m_tvalid = 1; m_ridx = n_ret; n_ret++; rp = (rp + 1) % N;
         end else if (tr_s) begin
            m_tvalid = 0;
         end
         if (req_f != '0) begin
            for (int e = 0; e < N; e++)
               if (req_f[e]) begin
                  eng_busy[e] = 1; eng_cnt[e] = pick_lat(e) - 1;
                  eng_data[e] = {16'(ey_s), 16'(ex_s)};
               end
            n_iss++; ip = (ip + 1) % N;
         end
         if (start_s && !mb_pre) begin m_busy = 1; n_iss = 0; n_ret = 0; end
         for (int e = 0; e < N; e++) eng_stall[e] = rand_stall && ($urandom_range(0, 3) == 0);
      end
   endtask

   task automatic run_case(input int idx, input case_t c);
      int cyc;
      bit did_rst;
      lat0 = c.lat0; lat1 = c.lat1; rand_lat = c.rlat; rand_stall = c.rstall;
      rmode = c.rmode; phase = 0; beats = 0; fds = 0; frames = 0; did_rst = 0; cyc = 0;
      continuous = (c.nframes > 1);
      start = 1'b1; step(); start = 1'b0;
      while (m_busy && cyc < 3000) begin
         continuous = (frames < c.nframes - 1);
         start = c.mid_start && (cyc == 10);
         if (c.rst_after != 0 && !did_rst && beats == c.rst_after) begin
            did_rst = 1;
            rst = 1'b1; step(); rst = 1'b0;
            chk("rst_tdata", tdata, 0);
            chk("rst_tvalid", tvalid, 0);
            chk("rst_tuser", tuser, 0);
            chk("rst_tlast", tlast, 0);
            chk("rst_busy", busy, 0);
            chk("rst_req", req_valid, 0);
            chk("rst_rsp", rsp_ready, 0);
            start = 1'b1; step(); start = 1'b0;
         end else begin
            step();
         end
         cyc++;
      end
      start = 1'b0; continuous = 1'b0;
      chk($sformatf("case%0d_timeout", idx), cyc < 3000, 1);
      repeat (3) step();
      chk($sformatf("case%0d_beats", idx), beats, c.exp_beats);
      chk($sformatf("case%0d_frame_done", idx), fds, c.exp_fd);
   endtask

   case_t tbl[8];

   initial begin
      //            lat0 lat1 rlat rstall rmode nfr mid rst beats fd
      tbl[0] = '{3, 3, 0, 0, 0, 1, 0, 0, 8, 1};
      tbl[1] = '{9, 1, 0, 0, 0, 1, 0, 0, 8, 1};
      tbl[2] = '{3, 3, 0, 0, 1, 1, 0, 0, 8, 1};
      tbl[3] = '{2, 2, 0, 0, 0, 2, 1, 0, 16, 2};
      tbl[4] = '{3, 3, 0, 0, 0, 1, 0, 3, 11, 1};
      tbl[5] = '{1, 1, 1, 1, 2, 3, 0, 0, 24, 3};
      tbl[6] = '{1, 1, 1, 1, 2, 2, 1, 0, 16, 2};
      tbl[7] = '{1, 5, 0, 1, 2, 1, 0, 0, 8, 1};
      checks = 0; failures = 0;
      rst = 1'b1; start = 1'b0; continuous = 1'b0; tready = 1'b0;
      req_ready = '0; rsp_valid = '0; rsp_data = '0; rmode = 0; phase = 0;
      start1 = 1'b0; rqr1 = 1'b1; rsv1 = 1'b0; rsd1 = '0; tready1 = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_tvalid", tvalid, 0);
      chk("reset_tdata", tdata, 0);
      chk("reset_tuser", tuser, 0);
      chk("reset_tlast", tlast, 0);
      chk("reset_busy", busy, 0);
      chk("reset_frame_done", frame_done, 0);
      chk("reset_req", req_valid, 0);
      chk("reset_rsp", rsp_ready, 0);
      chk("tkeep", tkeep, 4'hF);
      chk("reset_busy1", busy1, 0);
      rst = 1'b0;
      repeat (2) step();
      for (int i = 0; i < 8; i++) run_case(i, tbl[i]);

      // single-engine 1x1 frame
      start1 = 1'b1; @(negedge clk); start1 = 1'b0;
      for (int i = 0; i < 20 && !rqv1; i++) @(negedge clk);
      chk("t6_req_valid", rqv1, 1);
      chk("t6_xy", {ex1, ey1}, 0);
      chk("t6_busy", busy1, 1);
      @(negedge clk);
      rqr1 = 1'b0;
      chk("t6_req_done", rqv1, 0);
      rsd1 = 32'hCAFE_0001; rsv1 = 1'b1;
      for (int i = 0; i < 20 && !rsr1; i++) @(negedge clk);
      chk("t6_rsp_ready", rsr1, 1);
      @(negedge clk);
      rsv1 = 1'b0;
      #1;
      chk("t6_beat", {tvalid1, tuser1, tlast1}, 3'b111);
      chk("t6_tdata", tdata1, 32'hCAFE_0001);
      chk("t6_rsp_after", rsr1, 0);
      tready1 = 1'b1;
      @(negedge clk);
      chk("t6_frame_done", fd1, 1);
      chk("t6_idle", {busy1, tvalid1}, 2'b00);
      @(negedge clk);
      chk("t6_fd_pulse", fd1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
